// File: rtl/hb3_motor_emu.sv
// hb3_motor_emu: PWM-duty-driven quadrature encoder emulator; define HB3EMU_INERTIA_EN for slew-limited speed changes
module hb3_motor_emu #(
  parameter int PWM_PERIOD = 100,
  parameter int STEP = 21475,
  parameter int ACC_W = 32,
  parameter int SLEW = 214750
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        En,
  input  logic        Dir,
  output logic        SA,
  output logic        SB,
  output logic [7:0]  duty_meas,
  output logic [31:0] position
);
  logic [7:0] win_cnt, high_cnt, duty_new;
  logic [ACC_W-1:0] inc, acc, acc_sum, target, inc_next;
  logic [1:0] q, q_next;
  logic carry, win_end;
  assign win_end = win_cnt == 8'(PWM_PERIOD - 1);
  assign duty_new = high_cnt + {7'd0, En};
  assign target = ACC_W'(duty_new) * ACC_W'(STEP);
  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, inc};
  assign q_next = Dir ? q + 2'd1 : q - 2'd1;
`ifdef HB3EMU_INERTIA_EN
  localparam logic [ACC_W-1:0] slew_inc = ACC_W'(SLEW);
  // move toward the new target by at most one slew step per window
  always_comb
    inc_next = target > inc ? (target - inc > slew_inc ? inc + slew_inc : target)
                            : (inc - target > slew_inc ? inc - slew_inc : target);
`else
  assign inc_next = target;
`endif
  // duty measurement window; speed is retargeted only at the window end
  always_ff @(posedge Clk)
    if (Rst) begin
      win_cnt   <= '0;
      high_cnt  <= '0;
      duty_meas <= '0;
      inc       <= '0;
    end else begin
      win_cnt  <= win_end ? '0 : win_cnt + 8'd1;
      high_cnt <= win_end ? '0 : duty_new;
      if (win_end) begin
        duty_meas <= duty_new;
        inc       <= inc_next;
      end
    end
  // phase accumulator; each carry advances the quadrature index in the sampled direction
  always_ff @(posedge Clk)
    if (Rst) begin
      acc      <= '0;
      q        <= '0;
      position <= '0;
      SA       <= 1'b0;
      SB       <= 1'b0;
    end else begin
      acc <= acc_sum;
      if (carry) begin
        q        <= q_next;
        position <= Dir ? position + 32'd1 : position - 32'd1;
        SA       <= q_next[1] ^ q_next[0];
        SB       <= q_next[1];
      end
    end
endmodule

// File: tb/tb_hb3_motor_emu.sv
// tb_hb3_motor_emu: directed stimulus with a cycle-accurate arithmetic model of the motor emulator
module tb_hb3_motor_emu;
  localparam int PERIOD = 100;
  localparam longint STEP_L = 21475;
  localparam longint SLEW_L = 214750;
  logic Clk = 1'b0, Rst = 1'b1, En = 1'b0, Dir = 1'b1;
  logic SA, SB;
  logic [7:0] duty_meas;
  logic [31:0] position;
  int n_cmp = 0, n_bad = 0, n_print = 0;
  longint m_phase = 0, m_inc = 0, tgt = 0;
  int m_high = 0, m_duty = 0, cyc = 0;
  logic [31:0] m_pos = '0;
  logic [1:0] qtab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  hb3_motor_emu dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Dir(Dir),
    .SA(SA), .SB(SB), .duty_meas(duty_meas), .position(position)
  );

  always #5 Clk = ~Clk;

  // model: unbounded phase, a step whenever it crosses a multiple of 2^32; quadrature follows position mod 4
  always @(posedge Clk) begin
    if (Rst) begin
      m_phase = 0; m_inc = 0; m_high = 0; m_duty = 0; m_pos = '0; cyc = 0;
    end else begin
      if (((m_phase + m_inc) >> 32) != (m_phase >> 32)) m_pos = Dir ? m_pos + 32'd1 : m_pos - 32'd1;
      m_phase = m_phase + m_inc;
      m_high = m_high + int'(En);
      if (cyc % PERIOD == PERIOD - 1) begin
        m_duty = m_high;
        m_high = 0;
        tgt = (longint'(m_duty) * STEP_L) & 64'hFFFF_FFFF;
`ifdef HB3EMU_INERTIA_EN
        if (tgt > m_inc) m_inc = (tgt - m_inc > SLEW_L) ? m_inc + SLEW_L : tgt;
        else m_inc = (m_inc - tgt > SLEW_L) ? m_inc - SLEW_L : tgt;
`else
        m_inc = tgt;
`endif
      end
      cyc++;
    end
  end

  // every cycle: all outputs against the model
  always @(negedge Clk) begin
    n_cmp++;
    if ({SA, SB, duty_meas, position} !== {qtab[m_pos[1:0]], 8'(m_duty), m_pos}) begin
      n_bad++;
      if (n_print < 20) begin
        n_print++;
        $display("FAIL model cyc=%0d: got SA/SB=%b%b duty=%0d pos=%0d, want SA/SB=%b duty=%0d pos=%0d",
                 cyc, SA, SB, duty_meas, position, qtab[m_pos[1:0]], m_duty, m_pos);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_step(input string nm);
    logic [31:0] p0;
    bit ok;
    p0 = position;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (position != p0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic restart(input logic en_v, input logic dir_v);
    @(negedge Clk);
    Rst = 1'b1; En = en_v; Dir = dir_v;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    int t1, rises;
    logic sa_prev;
    // reset, no drive
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (10000) @(negedge Clk);
    chk("idle_pos", position, 0);
    chk("idle_duty", duty_meas, 0);
    chk("idle_sasb", {SA, SB}, 0);
    // full duty forward
    restart(1'b1, 1'b1);
    repeat (99) @(negedge Clk);
    chk("duty_before_end", duty_meas, 0);
    @(negedge Clk);
    chk("duty_full", duty_meas, 100);
    wait_step("s1");
`ifndef HB3EMU_INERTIA_EN
    chk("first_step_cycle", cyc, 2100);
`endif
    chk("s1_sasb", {SA, SB}, 2'b10);
    chk("s1_pos", position, 1);
    t1 = cyc;
    wait_step("s2");
    chk("step_interval_ok", (cyc - t1 >= 1999 && cyc - t1 <= 2001), 1);
    chk("s2_sasb", {SA, SB}, 2'b11);
    chk("s2_pos", position, 2);
    wait_step("s3");
    chk("s3_sasb", {SA, SB}, 2'b01);
    wait_step("s4");
    chk("s4_sasb", {SA, SB}, 2'b00);
    chk("s4_pos", position, 4);
    // direction flip at state 11
    wait_step("s5");
    wait_step("s6");
    chk("s6_sasb", {SA, SB}, 2'b11);
    Dir = 1'b0;
    wait_step("r1");
    chk("r1_sasb", {SA, SB}, 2'b10);
    chk("r1_pos", position, 5);
    wait_step("r2");
    chk("r2_sasb", {SA, SB}, 2'b00);
    chk("r2_pos", position, 4);
    wait_step("r3");
    chk("r3_sasb", {SA, SB}, 2'b01);
    chk("r3_pos", position, 3);
    // reset just ahead of the next carry
    Dir = 1'b1;
    wait_step("f1");
    chk("f1_pos", position, 4);
    repeat (1998) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_out_all_zero", {SA, SB, duty_meas, position}, 0);
    Rst = 1'b0;
    repeat (2099) @(negedge Clk);
    chk("no_early_step", position, 0);
`ifndef HB3EMU_INERTIA_EN
    @(negedge Clk);
    chk("step_after_rst", position, 1);
`endif
    // half duty rate
    restart(1'b0, 1'b1);
    rises = 0;
    sa_prev = SA;
    for (int i = 0; i < 30000; i++) begin
      En = (i % PERIOD) < 50;
      @(negedge Clk);
      if (SA && !sa_prev) rises++;
      sa_prev = SA;
    end
    chk("half_duty", duty_meas, 50);
    chk("half_pos_7pm1", (position >= 6 && position <= 8), 1);
    chk("half_sa_rises_2pm1", (rises >= 1 && rises <= 3), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
